clock_gen: RTL and testbench

Parametrised clock/strobe generator for the system: derives the CPU clock, the phase-shifted RAM clock and RAM write strobe, and the fixed half-rate SROM/VGA clocks from the single board clock. The CPU divide ratio is selectable at run time and changes only at CPU-period boundaries, so no runt pulses occur. An optional halt/single-step controller freezes the CPU clock domain cleanly for debug. Sits at the top of the design and feeds every clock consumer.

---
 rtl/clock_gen.sv | 195 +++++++++++++++++++
 tb/tb_clock_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_gen.sv
// clock_gen
// -----------------------------------------------------------------------------
// Derives every system clock from the single board clock:
//   - clk_cpu  : CPU clock, period 2^k board clocks, k selectable at run time
//   - clk_ram  : RAM clock, offset a quarter of a CPU period from clk_cpu
//   - clk_wren : RAM write strobe
//   - clk_srom / clk_vga : free-running clk/2
// The divide exponent only changes at a CPU period boundary, so every CPU
// period is complete and no runt pulses are produced. All outputs come
// straight from flops that are loaded with the decode of the next state.
//
// Optional feature (macro CLOCK_GEN_STEP_EN):
//   defined   -> halt / single-step controller driven by run and step
//   undefined -> run and step are ignored, halted is tied low, the counter
//                always runs; divide selection works the same way.
//
// Ports:
//   clk       in   board clock, all flops on the rising edge
//   reset     in   asynchronous, active-high
//   div_sel   in   requested divide exponent k (clamped to 2..MAX_LOG2)
//   run       in   1 = CPU clock runs, 0 = halt at the next period boundary
//   step      in   while halted, releases exactly one CPU period
//   clk_cpu   out  CPU clock
//   clk_ram   out  RAM clock
//   clk_wren  out  RAM write strobe
//   clk_srom  out  clk/2
//   clk_vga   out  clk/2, identical to clk_srom
//   cpu_tick  out  one-clk pulse coincident with each clk_cpu rise
//   halted    out  CPU clock domain frozen
//   div_cur   out  divide exponent currently in effect
// -----------------------------------------------------------------------------
module clock_gen #(
  parameter int MAX_LOG2    = 6,
  parameter int DEFAULT_DIV = 4,
  parameter int DIV_SEL_W   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_SEL_W-1:0] div_sel,
  input  logic                 run,
  input  logic                 step,
  output logic                 clk_cpu,
  output logic                 clk_ram,
  output logic                 clk_wren,
  output logic                 clk_srom,
  output logic                 clk_vga,
  output logic                 cpu_tick,
  output logic                 halted,
  output logic [DIV_SEL_W-1:0] div_cur
);

  localparam int CW = MAX_LOG2;
  localparam logic [DIV_SEL_W-1:0] K_MIN = DIV_SEL_W'(2);
  localparam logic [DIV_SEL_W-1:0] K_MAX = DIV_SEL_W'(MAX_LOG2);
  localparam logic [DIV_SEL_W-1:0] K_RST = DIV_SEL_W'(DEFAULT_DIV);
  localparam logic [DIV_SEL_W-1:0] K_ONE = DIV_SEL_W'(1);
  localparam logic [DIV_SEL_W-1:0] K_TWO = DIV_SEL_W'(2);

  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_n;
  logic [DIV_SEL_W-1:0] k;
  logic [DIV_SEL_W-1:0] k_n;
  logic [DIV_SEL_W-1:0] k_sel;
  logic                 wrap;
  logic                 srom_q;
  logic                 cpu_n;
  logic                 ram_n;
  logic                 wren_n;
  logic                 tick_n;

`ifdef CLOCK_GEN_STEP_EN
  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_STEP
  } state_t;

  state_t state;
  state_t state_n;
  logic   halted_n;
`else
  logic unused_inputs;
  assign unused_inputs = run ^ step;
`endif

  // Clamp the requested exponent into the legal range 2..MAX_LOG2.
  always_comb begin
    if (div_sel < K_MIN) begin
      k_sel = K_MIN;
    end else if (div_sel > K_MAX) begin
      k_sel = K_MAX;
    end else begin
      k_sel = div_sel;
    end
  end

  // Period end: cnt == 2^k - 1. The all-ones mask shifted left by k and
  // inverted gives exactly the low k bits set; for k == CW the shift clears
  // everything so the mask becomes all ones.
  assign wrap = (cnt == ~({CW{1'b1}} << k));

  // Next-state logic. A new k is only accepted at a period boundary (or
  // while frozen), which is what keeps every CPU period complete.
  always_comb begin
    cnt_n = cnt + CW'(1);
    k_n   = k;
`ifdef CLOCK_GEN_STEP_EN
    state_n = state;
    case (state)
      S_RUN, S_STEP: begin
        // A step period ends exactly like a run period: run decides
        // whether the next period is released or the domain freezes.
        if (wrap) begin
          cnt_n = '0;
          k_n   = k_sel;
          if (run) begin
            state_n = S_RUN;
          end else begin
            state_n = S_HALT;
          end
        end
      end
      S_HALT: begin
        cnt_n = '0;
        k_n   = k_sel;
        if (run) begin
          state_n = S_RUN;
          cnt_n   = CW'(1);
        end else if (step) begin
          state_n = S_STEP;
          cnt_n   = CW'(1);
        end
      end
      default: begin
        state_n = S_RUN;
        cnt_n   = '0;
      end
    endcase
    halted_n = (state_n == S_HALT);
`else
    if (wrap) begin
      cnt_n = '0;
      k_n   = k_sel;
    end
`endif
  end

  // Output decode of the next state, so the registered outputs line up with
  // the registered counter. A held counter of 0 yields the idle levels.
  always_comb begin
    cpu_n  = |(cnt_n & (CW'(1) << (k_n - K_ONE)));
    ram_n  = ~|(cnt_n & (CW'(1) << (k_n - K_TWO)));
    wren_n = cpu_n ^ ~ram_n;
    tick_n = (cnt_n == (CW'(1) << (k_n - K_ONE)));
  end

  // Single register bank: counter, exponent, controller state and every
  // clock output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      k        <= K_RST;
      clk_cpu  <= 1'b0;
      clk_ram  <= 1'b1;
      clk_wren <= 1'b0;
      cpu_tick <= 1'b0;
      srom_q   <= 1'b0;
`ifdef CLOCK_GEN_STEP_EN
      state    <= S_RUN;
      halted   <= 1'b0;
`endif
    end else begin
      cnt      <= cnt_n;
      k        <= k_n;
      clk_cpu  <= cpu_n;
      clk_ram  <= ram_n;
      clk_wren <= wren_n;
      cpu_tick <= tick_n;
      srom_q   <= ~srom_q;
`ifdef CLOCK_GEN_STEP_EN
      state    <= state_n;
      halted   <= halted_n;
`endif
    end
  end

`ifndef CLOCK_GEN_STEP_EN
  assign halted = 1'b0;
`endif

  assign clk_srom = srom_q;
  assign clk_vga  = srom_q;
  assign div_cur  = k;

endmodule

// File: tb/tb_clock_gen.sv
// tb_clock_gen
// -----------------------------------------------------------------------------
// Self-checking bench for clock_gen. A reference model tracks the position
// inside the current CPU period, the exponent in effect and whether the CPU
// domain is frozen; expected outputs are derived from that position with
// plain arithmetic. Follows CLOCK_GEN_STEP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_clock_gen;

  localparam int MAX_LOG2    = 6;
  localparam int DEFAULT_DIV = 4;
  localparam int DIV_SEL_W   = 3;
`ifdef CLOCK_GEN_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // {clk_cpu, clk_ram, clk_wren, clk_srom, clk_vga, cpu_tick, halted, div_cur}
  localparam logic [9:0] RST_VEC = {7'b0100000, 3'(DEFAULT_DIV)};

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DIV_SEL_W-1:0] div_sel;
  logic                 run;
  logic                 step;
  logic                 clk_cpu;
  logic                 clk_ram;
  logic                 clk_wren;
  logic                 clk_srom;
  logic                 clk_vga;
  logic                 cpu_tick;
  logic                 halted;
  logic [DIV_SEL_W-1:0] div_cur;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state.
  int m_pos;
  int m_k;
  int m_edges;
  int m_ticks;
  bit m_frozen;
  bit m_tick;
  bit m_seen_halt;

  // Observed event bookkeeping.
  int d_ticks;
  bit d_seen_halt;

  clock_gen #(
    .MAX_LOG2   (MAX_LOG2),
    .DEFAULT_DIV(DEFAULT_DIV),
    .DIV_SEL_W  (DIV_SEL_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .div_sel (div_sel),
    .run     (run),
    .step    (step),
    .clk_cpu (clk_cpu),
    .clk_ram (clk_ram),
    .clk_wren(clk_wren),
    .clk_srom(clk_srom),
    .clk_vga (clk_vga),
    .cpu_tick(cpu_tick),
    .halted  (halted),
    .div_cur (div_cur)
  );

  always #5 clk = ~clk;

  function automatic int clamp_k(input int s);
    if (s < 2) return 2;
    if (s > MAX_LOG2) return MAX_LOG2;
    return s;
  endfunction

  function automatic logic [9:0] obs_vec();
    return {clk_cpu, clk_ram, clk_wren, clk_srom, clk_vga, cpu_tick, halted, div_cur};
  endfunction

  // Expected outputs from the position within the period: the CPU clock is
  // high in the second half, the RAM clock high in the first quarter of each
  // half, the write strobe high in the middle two quarters.
  function automatic logic [9:0] exp_vec();
    int  half = 1 << (m_k - 1);
    int  q    = 1 << (m_k - 2);
    bit  cpu  = (m_pos >= half);
    bit  ram  = ((m_pos % half) < q);
    bit  wren = (m_pos >= q) && (m_pos < 3 * q);
    bit  srom = (m_edges % 2) == 1;
    return {cpu, ram, wren, srom, srom, m_tick, m_frozen, 3'(m_k)};
  endfunction

  task automatic model_reset();
    m_pos    = 0;
    m_k      = DEFAULT_DIV;
    m_edges  = 0;
    m_frozen = 1'b0;
    m_tick   = 1'b0;
  endtask

  // Advance the model by one board clock using the inputs seen at the edge.
  task automatic model_update();
    int sel    = clamp_k(int'(div_sel));
    int period = 1 << m_k;
    m_edges++;
    if (m_frozen) begin
      m_k = sel;
      if (run || step) begin
        m_frozen = 1'b0;
        m_pos    = 1;
      end else begin
        m_pos = 0;
      end
    end else if (m_pos == period - 1) begin
      m_pos = 0;
      m_k   = sel;
      if (STEP_EN && !run) m_frozen = 1'b1;
    end else begin
      m_pos++;
    end
    m_tick = !m_frozen && (m_pos == (1 << (m_k - 1)));
    if (m_tick) m_ticks++;
    if (m_frozen) m_seen_halt = 1'b1;
  endtask

  // One board clock: model follows the edge, outputs sampled 1 ns later.
  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    if (cpu_tick) d_ticks++;
    if (halted) d_seen_halt = 1'b1;
  endtask

  task automatic applyStimulus(input int sel, input bit r, input bit s);
    div_sel = DIV_SEL_W'(sel);
    run     = r;
    step    = s;
  endtask

  task automatic test_reset();
    applyStimulus(4, 1'b1, 1'b0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (obs_vec() !== RST_VEC) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got=%b exp=%b", obs_vec(), RST_VEC);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle();
    tests_run++;
    if (obs_vec() !== exp_vec()) begin
      tests_failed++;
      $display("[TB] FAIL first_edge got=%b exp=%b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_basic();
    d_ticks = 0;
    for (int i = 1; i < 64; i++) begin
      cycle();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL basic cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    tests_run++;
    if (d_ticks !== 4) begin
      tests_failed++;
      $display("[TB] FAIL basic_tick_count got=%0d exp=4", d_ticks);
    end
  endtask

  task automatic test_div_change();
    int run_len = 0;
    int min_len = 1000;
    bit prev;
    bit started = 1'b0;
    for (int i = 0; i < 64 && m_pos != 5; i++) begin
      cycle();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL div_sync got=%b exp=%b", obs_vec(), exp_vec());
      end
    end
    applyStimulus(2, 1'b1, 1'b0);
    prev = clk_cpu;
    for (int i = 0; i < 40; i++) begin
      cycle();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL div_change cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      run_len++;
      if (clk_cpu !== prev) begin
        if (started && run_len < min_len) min_len = run_len;
        started = 1'b1;
        run_len = 0;
        prev    = clk_cpu;
      end
    end
    tests_run++;
    if (min_len < 2) begin
      tests_failed++;
      $display("[TB] FAIL div_min_phase got=%0d exp>=2", min_len);
    end
  endtask

  task automatic test_clamp();
    for (int s = 0; s < 2; s++) begin
      int sel  = (s == 0) ? 0 : 7;
      int expk = (s == 0) ? 2 : MAX_LOG2;
      int gap  = 0;
      applyStimulus(sel, 1'b1, 1'b0);
      for (int i = 0; i < 72; i++) begin
        cycle();
        tests_run++;
        if (obs_vec() !== exp_vec()) begin
          tests_failed++;
          $display("[TB] FAIL clamp sel=%0d got=%b exp=%b", sel, obs_vec(), exp_vec());
        end
      end
      tests_run++;
      if (div_cur !== DIV_SEL_W'(expk)) begin
        tests_failed++;
        $display("[TB] FAIL clamp_div_cur sel=%0d got=%0d exp=%0d", sel, div_cur, expk);
      end
      for (int i = 0; i < 70 && !cpu_tick; i++) cycle();
      cycle();
      gap = 1;
      while (!cpu_tick && gap < 80) begin
        cycle();
        gap++;
      end
      tests_run++;
      if (gap !== (1 << expk)) begin
        tests_failed++;
        $display("[TB] FAIL clamp_period sel=%0d got=%0d exp=%0d", sel, gap, 1 << expk);
      end
    end
  endtask

  task automatic test_halt();
    applyStimulus(4, 1'b1, 1'b0);
    for (int i = 0; i < 150 && !(m_k == 4 && m_pos == 3); i++) cycle();
    tests_run++;
    if (!(m_k == 4 && m_pos == 3)) begin
      tests_failed++;
      $display("[TB] FAIL halt_sync_timeout got=pos%0d exp=pos3", m_pos);
    end
    applyStimulus(4, 1'b0, 1'b0);
    m_seen_halt = 1'b0;
    d_seen_halt = 1'b0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL halt cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
    tests_run++;
    if (d_seen_halt !== m_seen_halt) begin
      tests_failed++;
      $display("[TB] FAIL halt_entry got=%0b exp=%0b", d_seen_halt, m_seen_halt);
    end
  endtask

  task automatic test_step();
    applyStimulus(4, 1'b0, 1'b1);
    d_ticks = 0;
    m_ticks = 0;
    cycle();
    applyStimulus(4, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL step cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      cycle();
    end
    tests_run++;
    if (d_ticks !== m_ticks) begin
      tests_failed++;
      $display("[TB] FAIL step_tick_count got=%0d exp=%0d", d_ticks, m_ticks);
    end
    applyStimulus(4, 1'b1, 1'b1);
    cycle();
    applyStimulus(4, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL resume cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
      cycle();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) div_sel = DIV_SEL_W'($urandom_range(0, 7));
      run  = ($urandom_range(0, 5) != 0);
      step = ($urandom_range(0, 7) == 0);
      cycle();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL random cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    applyStimulus(4, 1'b1, 1'b0);
    for (int i = 0; i < 200 && !(m_k == 4 && m_pos == 10); i++) cycle();
    tests_run++;
    if (!(m_k == 4 && m_pos == 10)) begin
      tests_failed++;
      $display("[TB] FAIL async_sync_timeout got=pos%0d exp=pos10", m_pos);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (obs_vec() !== RST_VEC) begin
      tests_failed++;
      $display("[TB] FAIL async_reset got=%b exp=%b", obs_vec(), RST_VEC);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      tests_run++;
      if (obs_vec() !== exp_vec()) begin
        tests_failed++;
        $display("[TB] FAIL after_reset cyc=%0d got=%b exp=%b", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_ticks     = 0;
    m_seen_halt = 1'b0;
    d_ticks     = 0;
    d_seen_halt = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_div_change();
    test_clamp();
    test_halt();
    test_step();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
